// File: rtl/fifo_word_packer.sv
// Packs WORDS consecutive entries from a show-ahead FIFO read port into one wide
// word, presented on a registered valid/ready stream; flush emits a partial word.
module fifo_word_packer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WORDS = 2,
    parameter int unsigned CW    = $clog2(WORDS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   empty,
    input  logic [WIDTH-1:0]       rdata,
    output logic                   re,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] out_data,
    output logic [CW-1:0]          out_count
);

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WIDTH*WORDS-1:0] data_q, data_d;
    logic                   capture;

    assign capture   = re;
    assign out_data  = data_q;
    assign out_count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        data_d  = data_q;
        unique case (state_q)
            StCollect: begin
                if (capture) begin
                    data_d[int'(cnt_q) * int'(WIDTH) +: WIDTH] = rdata;
                end
                if (capture && (cnt_q == CW'(WORDS - 1))) begin
                    state_d = StHold;
                    count_d = CW'(WORDS);
                    cnt_d   = '0;
                end else if (flush && (capture || (cnt_q != '0))) begin
                    // Slots above the last capture are still zero from the previous clear.
                    state_d = StHold;
                    count_d = cnt_q + CW'(capture);
                    cnt_d   = '0;
                end else if (capture) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StCollect;
                    count_d = '0;
                    data_d  = '0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_comb begin
        re        = (state_q == StCollect) & ~empty & rst_n;
        out_valid = (state_q == StHold);
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (WIDTH=4, WORDS=2): inputs change just after
// the falling edge and outputs are checked 1ns later, well before the rising edge.
module tb_fifo_word_packer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned WORDS = 2;
    localparam int unsigned CW    = $clog2(WORDS + 1);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   empty;
    logic [WIDTH-1:0]       rdata;
    logic                   re;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH*WORDS-1:0] out_data;
    logic [CW-1:0]          out_count;

    int checks = 0;
    int errors = 0;

    fifo_word_packer #(
        .WIDTH(WIDTH),
        .WORDS(WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .empty    (empty),
        .rdata    (rdata),
        .re       (re),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Check the full output set in one go.
    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic [1:0] c, input logic r);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".count"}, 32'(out_count), 32'(c));
        check({tag, ".re"},    32'(re),        32'(r));
    endtask

    initial begin
        rst_n     = 1'b0;
        empty     = 1'b0;
        rdata     = 4'h3;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset held with a non-empty FIFO and ready downstream
        #1 check_out("rst0", 1'b0, 8'h00, 2'd0, 1'b0);
        tick(); tick();
        #1 check_out("rst1", 1'b0, 8'h00, 2'd0, 1'b0);

        // Steady stream: 0x3 then 0xA -> 0xA3
        tick(); rst_n = 1'b1; rdata = 4'h3;
        #1 check("st.re0", 32'(re), 32'd1);
        tick(); rdata = 4'hA;
        #1 check("st.re1", 32'(re), 32'd1);
        check("st.partial", 32'(out_data), 32'h03);
        tick(); rdata = 4'h3;
        #1 check_out("st.word", 1'b1, 8'hA3, 2'd2, 1'b0);
        out_ready = 1'b0;   // handshake still happens on this edge? no: set below
        out_ready = 1'b1;
        tick();
        #1 check_out("st.after", 1'b0, 8'h00, 2'd0, 1'b1);

        // Backpressure: out_ready low for 5 cycles after out_valid
        out_ready = 1'b0;
        tick(); rdata = 4'hA;
        tick(); rdata = 4'h3;
        for (int i = 0; i < 5; i++) begin
            #1 check_out("bp.hold", 1'b1, 8'hA3, 2'd2, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick(); empty = 1'b1; rdata = 4'h7;
        #1 check_out("bp.done", 1'b0, 8'h00, 2'd0, 1'b0);

        // Partial flush: capture 0x7, then empty and flush
        tick(); empty = 1'b0; rdata = 4'h7;
        #1 check("pf.re", 32'(re), 32'd1);
        tick(); empty = 1'b1; flush = 1'b1;
        #1 check("pf.pre", 32'(out_valid), 32'd0);
        tick(); flush = 1'b0;
        #1 check_out("pf.word", 1'b1, 8'h07, 2'd1, 1'b0);
        tick();
        #1 check("pf.after", 32'(out_valid), 32'd0);
        flush = 1'b1;   // cnt=0, empty=1: ignored
        tick(); flush = 1'b0;
        #1 check_out("pf.ignored", 1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        #1 check("pf.ignored2", 32'(out_valid), 32'd0);

        // Flush coincident with the completing capture
        empty = 1'b0; rdata = 4'h5;
        tick(); rdata = 4'hC; flush = 1'b1;
        #1 check("fc.re", 32'(re), 32'd1);
        tick(); flush = 1'b0; empty = 1'b1;
        #1 check_out("fc.word", 1'b1, 8'hC5, 2'd2, 1'b0);
        tick();
        #1 check("fc.noextra0", 32'(out_valid), 32'd0);
        tick();
        #1 check("fc.noextra1", 32'(out_valid), 32'd0);

        // Flush coincident with a capture into slot 0 gives a one-entry word
        empty = 1'b0; rdata = 4'h9; flush = 1'b1;
        tick(); flush = 1'b0; empty = 1'b1;
        #1 check_out("f0.word", 1'b1, 8'h09, 2'd1, 1'b0);
        tick();
        #1 check("f0.after", 32'(out_valid), 32'd0);

        // Asynchronous reset while holding a word
        out_ready = 1'b0; empty = 1'b0; rdata = 4'h6;
        tick(); rdata = 4'hB;
        tick();
        #1 check_out("ar.hold", 1'b1, 8'hB6, 2'd2, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_out("ar.reset", 1'b0, 8'h00, 2'd0, 1'b0);
        tick(); rst_n = 1'b1; rdata = 4'h1;
        #1 check("ar.re", 32'(re), 32'd1);
        tick(); rdata = 4'h2;
        #1 check("ar.slot0", 32'(out_data), 32'h01);
        tick(); empty = 1'b1;
        #1 check_out("ar.word", 1'b1, 8'h21, 2'd2, 1'b0);
        out_ready = 1'b1;
        tick();
        #1 check("ar.after", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
